// File: rtl/writeback.sv
// Writeback stage: retires ALU results to the register file and runs single
// outstanding store/load transactions on the data-memory port.
module writeback (
    input  logic        clk,
    input  logic        resetb,
    input  logic        wb_valid,
    input  logic [31:0] wb_result,
    input  logic        wb_memwr,
    input  logic        wb_alu2reg,
    input  logic        wb_mem2reg,
    input  logic [4:0]  wb_dst_sel,
    input  logic [1:0]  wb_raddr,
    input  logic [2:0]  wb_aluop,
    input  logic [31:0] wb_waddr,
    input  logic [3:0]  wb_wstrb,
    input  logic [31:0] wb_wdata,
    output logic        wb_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata
);

    typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  raddr_q, raddr_d;
    logic [2:0]  aluop_q, aluop_d;
    logic [4:0]  dst_q, dst_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]  dmem_wstrb_q, dmem_wstrb_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic        reg_we_q, reg_we_d;
    logic [4:0]  reg_waddr_q, reg_waddr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic        unused_addr_bits;

    // Store addresses are word-aligned on the bus; the low bits live in wstrb.
    assign unused_addr_bits = ^wb_waddr[1:0];

    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [1:0]  raddr,
                                                 input logic [2:0]  aluop);
        logic [7:0]  b;
        logic [15:0] h;
        case (raddr)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = raddr[1] ? rdata[31:16] : rdata[15:0];
        case (aluop)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = rdata;
        endcase
    endfunction

    assign wb_stall = (state_q != IDLE) || (wb_valid && (wb_memwr || wb_mem2reg));

    always_comb begin
        state_d      = state_q;
        raddr_d      = raddr_q;
        aluop_d      = aluop_q;
        dst_d        = dst_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wstrb_d = dmem_wstrb_q;
        dmem_wdata_d = dmem_wdata_q;
        reg_we_d     = 1'b0;
        reg_waddr_d  = reg_waddr_q;
        reg_wdata_d  = reg_wdata_q;
        case (state_q)
            IDLE: begin
                if (wb_valid) begin
                    if (wb_memwr) begin
                        state_d      = ST_REQ;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = 1'b1;
                        dmem_addr_d  = {wb_waddr[31:2], 2'b00};
                        dmem_wstrb_d = wb_wstrb;
                        dmem_wdata_d = wb_wdata;
                    end else if (wb_mem2reg) begin
                        state_d      = LD_REQ;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = 1'b0;
                        dmem_addr_d  = {wb_result[31:2], 2'b00};
                        dmem_wstrb_d = 4'b0000;
                        raddr_d      = wb_raddr;
                        aluop_d      = wb_aluop;
                        dst_d        = wb_dst_sel;
                    end else if (wb_alu2reg) begin
                        reg_we_d    = (wb_dst_sel != 5'd0);
                        reg_waddr_d = wb_dst_sel;
                        reg_wdata_d = wb_result;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_ready) begin
                    state_d    = IDLE;
                    dmem_req_d = 1'b0;
                end
            end
            LD_REQ: begin
                if (dmem_ready) begin
                    state_d    = LD_WAIT;
                    dmem_req_d = 1'b0;
                end
            end
            LD_WAIT: begin
                if (dmem_rvalid) begin
                    state_d     = IDLE;
                    reg_we_d    = (dst_q != 5'd0);
                    reg_waddr_d = dst_q;
                    reg_wdata_d = load_extract(dmem_rdata, raddr_q, aluop_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            raddr_q      <= 2'd0;
            aluop_q      <= 3'd0;
            dst_q        <= 5'd0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_wstrb_q <= 4'd0;
            dmem_wdata_q <= 32'd0;
            reg_we_q     <= 1'b0;
            reg_waddr_q  <= 5'd0;
            reg_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            raddr_q      <= raddr_d;
            aluop_q      <= aluop_d;
            dst_q        <= dst_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wstrb_q <= dmem_wstrb_d;
            dmem_wdata_q <= dmem_wdata_d;
            reg_we_q     <= reg_we_d;
            reg_waddr_q  <= reg_waddr_d;
            reg_wdata_q  <= reg_wdata_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wstrb = dmem_wstrb_q;
    assign dmem_wdata = dmem_wdata_q;
    assign reg_we     = reg_we_q;
    assign reg_waddr  = reg_waddr_q;
    assign reg_wdata  = reg_wdata_q;

endmodule
